// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified instruction/data memory: cpu (port 0) and
// loader/debug (port 1), with round-robin ties, burst cap and read-return routing.
module mem_port_arbiter #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 16,
  parameter int maxBurst  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpuReq,
  input  logic                 cpuWe,
  input  logic [addrWidth-1:0] cpuAddr,
  input  logic [dataWidth-1:0] cpuWdata,
  output logic                 cpuGnt,
  output logic                 cpuRvalid,
  output logic [dataWidth-1:0] cpuRdata,
  input  logic                 ldrReq,
  input  logic                 ldrWe,
  input  logic [addrWidth-1:0] ldrAddr,
  input  logic [dataWidth-1:0] ldrWdata,
  output logic                 ldrGnt,
  output logic                 ldrRvalid,
  output logic [dataWidth-1:0] ldrRdata,
  output logic [addrWidth-1:0] memAddr,
  output logic [dataWidth-1:0] memWdata,
  output logic                 memRead,
  output logic                 memWrite,
  input  logic [dataWidth-1:0] memRdata
);

  localparam int CntW = $clog2(maxBurst);
  localparam logic [CntW-1:0] CntMax = CntW'(maxBurst - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LDR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            last_owner_q, last_owner_d;
  logic            rd_pending_q, rd_pending_d;
  logic            rd_port_q, rd_port_d;

  // Grants and read returns are masked while reset is held so nothing leaks out
  // in the cycle reset is first sampled.
  always_comb begin
    cpuGnt    = reset & (state_q == OWN_CPU) & cpuReq;
    ldrGnt    = reset & (state_q == OWN_LDR) & ldrReq;
    memRead   = (cpuGnt & ~cpuWe) | (ldrGnt & ~ldrWe);
    memWrite  = (cpuGnt & cpuWe) | (ldrGnt & ldrWe);
    memAddr   = '0;
    memWdata  = '0;
    if (cpuGnt) begin
      memAddr  = cpuAddr;
      memWdata = cpuWdata;
    end else if (ldrGnt) begin
      memAddr  = ldrAddr;
      memWdata = ldrWdata;
    end
    cpuRvalid = reset & rd_pending_q & ~rd_port_q;
    ldrRvalid = reset & rd_pending_q & rd_port_q;
    cpuRdata  = cpuRvalid ? memRdata : '0;
    ldrRdata  = ldrRvalid ? memRdata : '0;
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    rd_pending_d = memRead;
    rd_port_d    = ldrGnt;
    case (state_q)
      IDLE: begin
        if (cpuReq && ldrReq) begin
          state_d = last_owner_q ? OWN_CPU : OWN_LDR;
        end else if (cpuReq) begin
          state_d = OWN_CPU;
        end else if (ldrReq) begin
          state_d = OWN_LDR;
        end
      end
      OWN_CPU: begin
        if (!cpuReq || (ldrReq && burst_cnt_q == CntMax)) begin
          state_d      = ldrReq ? OWN_LDR : IDLE;
          last_owner_d = 1'b0;
          burst_cnt_d  = '0;
        end else if (ldrReq) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          burst_cnt_d = '0;
        end
      end
      OWN_LDR: begin
        if (!ldrReq || (cpuReq && burst_cnt_q == CntMax)) begin
          state_d      = cpuReq ? OWN_CPU : IDLE;
          last_owner_d = 1'b1;
          burst_cnt_d  = '0;
        end else if (cpuReq) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_port_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      rd_pending_q <= rd_pending_d;
      rd_port_q    <= rd_port_d;
    end
  end

endmodule
